// File: rtl/approx_seq_mult.sv
// Iterative signed/unsigned approximate multiplier: one partial-product row per clock,
// lower-part-OR accumulation. Define APPROX_SEQ_MULT_EXACT_EN to add y_exact/err_flag.
module approx_seq_mult #(
  parameter int unsigned NUM_BITS    = 8,
  parameter int unsigned APPROX_BITS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    signed_mode,
  input  logic [NUM_BITS-1:0]     a,
  input  logic [NUM_BITS-1:0]     b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*NUM_BITS-1:0]   y
`ifdef APPROX_SEQ_MULT_EXACT_EN
  ,
  output logic [2*NUM_BITS-1:0]   y_exact,
  output logic                    err_flag
`endif
);

  localparam int unsigned W  = 2 * NUM_BITS;
  localparam int unsigned CW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_BITS - 1);
  // Ones in the K approximate columns; zero when K = 0, making the accumulate exact.
  localparam logic [W-1:0] LO_MASK = {W{1'b1}} >> (W - APPROX_BITS);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_q, state_d;
  logic [W-1:0]        a_q, a_d;
  logic [NUM_BITS-1:0] b_q, b_d;
  logic                sgn_q, sgn_d;
  logic [W-1:0]        acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [W-1:0]        y_q, y_d;
  logic [W-1:0]        row;
  logic [W-1:0]        acc_sum;

  always_comb begin
    row = '0;
    if (b_q[cnt_q]) row = a_q << cnt_q;
    if (sgn_q && (cnt_q == LAST)) row = -row;
  end

  // Masked halves: the upper sum has zero low bits, so no carry crosses column K.
  assign acc_sum = ((acc_q | row) & LO_MASK)
                 | ((acc_q & ~LO_MASK) + (row & ~LO_MASK));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = signed_mode ? {{NUM_BITS{a[NUM_BITS-1]}}, a} : {{NUM_BITS{1'b0}}, a};
          b_d     = b;
          sgn_d   = signed_mode;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          y_d     = acc_sum;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign y         = y_q;

`ifdef APPROX_SEQ_MULT_EXACT_EN
  logic [W-1:0] shadow_q, shadow_d;
  logic [W-1:0] yx_q, yx_d;
  logic         err_q, err_d;
  logic [W-1:0] shadow_sum;

  assign shadow_sum = shadow_q + row;

  always_comb begin
    shadow_d = shadow_q;
    yx_d     = yx_q;
    err_d    = err_q;
    if (state_q == IDLE && in_valid) begin
      shadow_d = '0;
    end else if (state_q == BUSY) begin
      shadow_d = shadow_sum;
      if (cnt_q == LAST) begin
        yx_d  = shadow_sum;
        err_d = (acc_sum != shadow_sum);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      yx_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      yx_q     <= yx_d;
      err_q    <= err_d;
    end
  end

  assign y_exact  = yx_q;
  assign err_flag = err_q;
`endif

endmodule

// File: doc/approx_seq_mult.md
Name: approx_seq_mult

Overview:
Parametrised, iterative, signed/unsigned approximate multiplier.
- Produces one partial-product row per clock.
- Each row is accumulated with a lower-part-OR adder: the low APPROX_BITS columns are OR-ed and carry-free; the upper columns are added exactly.
- Sits in the approximate datapath as the area-lean, width-scalable successor to the fixed 2/3-bit combinational approximate multipliers.
- Has valid/ready handshakes on both sides.

Parameters:
NUM_BITS, 8, operand width N; legal range 2..16.
APPROX_BITS, 2, number K of low product columns accumulated approximately; legal range 0..NUM_BITS; 0 gives an exact product.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operands valid.
in_ready  output  1  block can accept operands; high only in IDLE.
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled at acceptance.
a  input  NUM_BITS  multiplicand.
b  input  NUM_BITS  multiplier.
out_valid  output  1  product y valid; high only in DONE.
out_ready  input  1  consumer accepts y.
y  output  2*NUM_BITS  approximate product, registered.

Behaviour:
- Reset is asynchronous and active-high. While asserted:
  - state = IDLE, out_valid = 0, y = 0, in_ready = 1, count = 0.
  - Internal operand and accumulator registers = 0.
- FSM has three states: IDLE, BUSY, DONE.
  - IDLE: in_ready = 1. On in_valid: latch a, b and signed_mode; clear accumulator; count = 0; go to BUSY.
  - BUSY: in_ready = 0. Each edge adds row[count] to the accumulator and increments count. The edge with count = N-1 moves to DONE and loads y from the new accumulator value.
  - DONE: out_valid = 1; y and out_valid are held stable. On out_ready: go to IDLE, out_valid falls.
- Latency: out_valid rises exactly N edges after the acceptance edge. Throughput is one product per N+2 cycles minimum.
  - in_ready is low from the acceptance edge until the edge after the out_ready handshake.
- in_valid is ignored outside IDLE. No operand is lost or reused.
- Row definition, all rows 2N bits wide, arithmetic modulo 2^(2N):
  - A = a sign-extended when signed_mode = 1, else zero-extended.
  - row[i] = b[i] ? (A << i) : 0.
  - In signed mode only, row[N-1] is replaced by its exact two's-complement negation, computed before accumulation.
- Approximate accumulate, with K = APPROX_BITS:
  - acc[K-1:0] <= acc[K-1:0] | row[K-1:0]
  - acc[2N-1:K] <= acc[2N-1:K] + row[2N-1:K]
  - No carry propagates from bit K-1 into bit K; the carry out of bit 2N-1 is discarded.
  - K = 0 gives an exact product in both modes.
- No early termination: all N rows are always processed, including b = 0.
- Asserting reset mid-BUSY or mid-DONE aborts the operation. Outputs return to reset values immediately; in_ready = 1 after deassertion.
- y changes only on the BUSY-to-DONE edge or on reset.

Optional Feature:
- Macro: APPROX_SEQ_MULT_EXACT_EN.
- Defined:
  - Adds output y_exact (2*NUM_BITS) and output err_flag (1).
  - A shadow accumulator sums the identical rows with full carry propagation.
  - y_exact and err_flag = (y != y_exact) load on the same edge as y, are held in DONE, and reset to 0.
- Undefined: these ports and the shadow logic do not exist. Core behaviour is identical in both cases.

Test Plan (NUM_BITS=4):
- K=0, signed, a=4'b1101 (-3), b=4'b0101 (5) -> out_valid exactly 4 edges after acceptance, y=8'hF1 (-15).
- K=2, unsigned, a=3, b=3 -> y=8'h07 (exact value would be 9).
- K=2, signed, a=4'hF (-1), b=4'hF (-1) -> y=8'hFF. Accumulator sequence after each BUSY edge: FF, FB, F7, FF.
- Backpressure: after the product is ready, hold out_ready=0 for 5 cycles with in_valid=1 and new operands -> y, out_valid=1 and in_ready=0 stay stable, no new acceptance. On out_ready=1 -> IDLE next edge, and the new operands are accepted the edge after.
- Reset pulse on the 2nd BUSY cycle -> out_valid=0, y=0, in_ready=1 immediately. The next operation (K=0, unsigned, a=15, b=15) yields y=8'hE1.
- With APPROX_SEQ_MULT_EXACT_EN, K=2, unsigned, a=3, b=3 -> y=8'h07, y_exact=8'h09, err_flag=1. With K=0, any operands -> err_flag=0.
